// File: rtl/riscv_pkg.sv
// Shared RV32 decode patterns, funct3 constants and writeback FSM state.
// Helpers classify instructions and derive load/store lane information.
package riscv_pkg;

    localparam logic [31:0] I_ALL_LOADS  = 32'b????_????_????_????_????_????_?000_0011;
    localparam logic [31:0] S_ALL_STORES = 32'b????_????_????_????_????_????_?010_0011;
    localparam logic [31:0] R_ALL        = 32'b????_????_????_????_????_????_?011_0011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } mwb_state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_R,
        OP_LOAD,
        OP_STORE
    } op_e;

    // Loads/stores with reserved funct3 encodings decode as no-ops.
    function automatic op_e classify(logic [31:0] ins);
        op_e op;
        op = OP_NONE;
        casez (ins)
            R_ALL: op = OP_R;
            I_ALL_LOADS: begin
                if (ins[14:12] inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                    op = OP_LOAD;
            end
            S_ALL_STORES: begin
                if (ins[14:12] inside {F3_SB, F3_SH, F3_SW})
                    op = OP_STORE;
            end
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_aligned(logic [1:0] a, logic [2:0] f3);
        logic ok;
        unique case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~a[0];
            default: ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strb(logic [1:0] a, logic [2:0] f3);
        logic [3:0] s;
        unique case (f3[1:0])
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = 4'b0011 << a;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/memory_writeback_if.sv
// Data-memory request/response bundle between writeback stage and memory.
// Request uses valid/ready; response is a single valid strobe with data.
interface memory_writeback_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, we, addr, wstrb, wdata,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wstrb, wdata,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/memory_writeback_load_extend.sv
// Byte-lane extraction and sign/zero extension of a loaded word.
// Purely combinational so a future cache can share it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] lane;

    assign lane = rdata >> {addr, 3'b000};

    always_comb begin
        data = lane;
        unique case (funct3)
            F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  data = {24'h0, lane[7:0]};
            F3_LHU:  data = {16'h0, lane[15:0]};
            default: data = lane;
        endcase
    end
endmodule

// File: rtl/memory_writeback.sv
// Memory/writeback stage: ALU writeback, data-memory loads and stores,
// misalignment and load-response timeout reporting.
module memory_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               instr_i,
    input  logic [31:0]               alu_result_i,
    input  logic [31:0]               store_data_i,
    output logic                      stall_o,
    memory_writeback_if.master        dmem,
    output logic                      rd_we_o,
    output logic [4:0]                rd_sel_o,
    output logic [31:0]               rd_data_o,
    output logic                      misalign_o,
    output logic                      bus_err_o
);
    localparam int CW = 16;
    localparam logic [CW-1:0] LIM = CW'(RSP_TIMEOUT - 1);

    mwb_state_e  state;
    op_e         op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mem;
    logic        al;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [CW-1:0] cnt;
    logic [31:0] ext;

    assign op  = classify(instr_i);
    assign rd  = instr_i[11:7];
    assign f3  = instr_i[14:12];
    assign mem = (op == OP_LOAD) || (op == OP_STORE);
    assign al  = is_aligned(alu_result_i[1:0], f3);

    assign stall_o = (state != IDLE);

    load_extend u_ext (
        .rdata  (dmem.rdata),
        .addr   (lo_q),
        .funct3 (f3_q),
        .data   (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            dmem.req_valid <= 1'b0;
            dmem.we        <= 1'b0;
            dmem.addr      <= '0;
            dmem.wstrb     <= '0;
            dmem.wdata     <= '0;
            rd_q           <= '0;
            f3_q           <= '0;
            lo_q           <= '0;
            cnt            <= '0;
            rd_we_o        <= 1'b0;
            rd_sel_o       <= '0;
            rd_data_o      <= '0;
            misalign_o     <= 1'b0;
            bus_err_o      <= 1'b0;
        end else begin
            rd_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        op == OP_R: begin
                            if (rd != 5'd0) begin
                                rd_we_o   <= 1'b1;
                                rd_sel_o  <= rd;
                                rd_data_o <= alu_result_i;
                            end
                        end
                        mem && !al: misalign_o <= 1'b1;
                        mem && al: begin
                            state          <= REQ;
                            dmem.req_valid <= 1'b1;
                            dmem.we        <= (op == OP_STORE);
                            dmem.addr      <= {alu_result_i[31:2], 2'b00};
                            dmem.wstrb     <= (op == OP_STORE) ?
                                store_strb(alu_result_i[1:0], f3) : 4'h0;
                            dmem.wdata     <= (op == OP_STORE) ?
                                store_data_i << {alu_result_i[1:0], 3'b000} : 32'h0;
                            rd_q           <= rd;
                            f3_q           <= f3;
                            lo_q           <= alu_result_i[1:0];
                        end
                        default: ;
                    endcase
                end
                REQ: begin
                    if (dmem.req_ready) begin
                        dmem.req_valid <= 1'b0;
                        cnt            <= '0;
                        state          <= dmem.we ? IDLE : RSP;
                    end
                end
                RSP: begin
                    // A response in the limit cycle takes priority over timeout.
                    if (dmem.rsp_valid) begin
                        if (rd_q != 5'd0) begin
                            rd_we_o   <= 1'b1;
                            rd_sel_o  <= rd_q;
                            rd_data_o <= ext;
                        end
                        state <= IDLE;
                    end else if (RSP_TIMEOUT != 0 && cnt == LIM) begin
                        bus_err_o <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_writeback.sv
// Self-checking bench: directed vector table, reset corners, random ops.
// Expected results come from a lane/size arithmetic model of the stage.
module tb_memory_writeback;
    import riscv_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        stall_o;
    logic        rd_we_o;
    logic [4:0]  rd_sel_o;
    logic [31:0] rd_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    int checks = 0;
    int failures = 0;

    memory_writeback_if dmem();

    memory_writeback #(.RSP_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_i      (instr),
        .alu_result_i (alu_result),
        .store_data_i (store_data),
        .stall_o      (stall_o),
        .dmem         (dmem),
        .rd_we_o      (rd_we_o),
        .rd_sel_o     (rd_sel_o),
        .rd_data_o    (rd_data_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, alu, sd, rdata;
        int          rdy, rsp;
        logic        noise;
        logic        req, st, mis, we, err;
        logic [4:0]  sel;
        logic [31:0] addr, wdata, data;
        logic [3:0]  wstrb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] i_load(logic [2:0] f, logic [4:0] rd);
        return {12'h0, 5'd1, f, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] s_store(logic [2:0] f);
        return {7'h0, 5'd2, 5'd1, f, 5'h0, 7'b0100011};
    endfunction

    function automatic logic [31:0] r_add(logic [4:0] rd);
        return {7'h0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic vec_t mk(logic [31:0] ins, alu, sd, rdata,
                                int rdy, rsp, logic req, st, mis, we, err,
                                logic [4:0] sel, logic [31:0] addr,
                                logic [3:0] wstrb, logic [31:0] wdata, data);
        vec_t v;
        v.instr = ins; v.alu = alu; v.sd = sd; v.rdata = rdata;
        v.rdy = rdy; v.rsp = rsp; v.noise = 1'b0;
        v.req = req; v.st = st; v.mis = mis; v.we = we; v.err = err;
        v.sel = sel; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
        v.data = data;
        return v;
    endfunction

    // Loaded value from byte offset, access size in bytes, unsigned flag.
    function automatic logic [31:0] ld_val(logic [31:0] w, int off, int n,
                                           logic u);
        logic [31:0] x, m;
        x = w >> (8 * off);
        if (n == 4) return x;
        m = (32'd1 << (8 * n)) - 1;
        x = x & m;
        if (!u && ((x >> (8 * n - 1)) & 1) == 1) x = x - (m + 1);
        return x;
    endfunction

    function automatic vec_t gen();
        vec_t v;
        int k, off, n;
        logic [2:0] f;
        logic [4:0] rd;
        v = mk(0, $urandom, $urandom, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 5), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.noise = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 9);
        rd = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 5) == 0) rd = 5'd0;
        off = int'(v.alu % 4);
        if (k < 2) begin
            v.instr = r_add(rd);
            v.we = (rd != 0); v.sel = rd; v.data = v.alu;
        end else if (k < 6) begin
            case ($urandom_range(0, 4))
                0: f = F3_LB;
                1: f = F3_LH;
                2: f = F3_LW;
                3: f = F3_LBU;
                default: f = F3_LHU;
            endcase
            n = 1 << f[1:0];
            v.instr = i_load(f, rd);
            if (off % n != 0) v.mis = 1'b1;
            else begin
                v.req = 1'b1;
                v.addr = v.alu - 32'(off);
                v.err = (v.rsp >= T);
                v.we = !v.err && rd != 0;
                v.sel = rd;
                v.data = ld_val(v.rdata, off, n, f[2]);
            end
        end else if (k < 9) begin
            f = 3'($urandom_range(0, 2));
            n = 1 << f;
            v.instr = s_store(f);
            if (off % n != 0) v.mis = 1'b1;
            else begin
                v.req = 1'b1; v.st = 1'b1;
                v.addr = v.alu - 32'(off);
                v.wstrb = 4'(((1 << n) - 1) << off);
                v.wdata = v.sd << (8 * off);
            end
        end else begin
            v.instr = {$urandom} & 32'hFFFF_FF80 | 32'h13;
        end
        return v;
    endfunction

    task automatic run(input vec_t v, input string nm);
        int k, ek;
        @(negedge clk);
        instr = v.instr; alu_result = v.alu; store_data = v.sd;
        @(posedge clk); #1;
        chk({nm, ".misalign"}, 32'(misalign_o), 32'(v.mis));
        if (!v.req) begin
            instr = '0;
            chk({nm, ".stall"}, 32'(stall_o), 0);
            chk({nm, ".req_valid"}, 32'(dmem.req_valid), 0);
            chk({nm, ".rd_we"}, 32'(rd_we_o), 32'(v.we));
            if (v.we) begin
                chk({nm, ".rd_sel"}, 32'(rd_sel_o), 32'(v.sel));
                chk({nm, ".rd_data"}, rd_data_o, v.data);
            end
            @(posedge clk); #1;
            chk({nm, ".pulse"}, {30'h0, rd_we_o, misalign_o}, 0);
            return;
        end
        chk({nm, ".stall"}, 32'(stall_o), 1);
        chk({nm, ".req_valid"}, 32'(dmem.req_valid), 1);
        chk({nm, ".we"}, 32'(dmem.we), 32'(v.st));
        chk({nm, ".addr"}, dmem.addr, v.addr);
        chk({nm, ".wstrb"}, 32'(dmem.wstrb), 32'(v.wstrb));
        if (v.st) chk({nm, ".wdata"}, dmem.wdata, v.wdata);
        for (int i = 0; i < v.rdy; i++) begin
            dmem.rsp_valid = v.noise; dmem.rdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
        end
        chk({nm, ".hold"}, {31'h0, dmem.req_valid} ^ dmem.addr, 32'd1 ^ v.addr);
        dmem.rsp_valid = 1'b0; dmem.req_ready = 1'b1;
        @(posedge clk); #1;
        dmem.req_ready = 1'b0;
        chk({nm, ".req_drop"}, 32'(dmem.req_valid), 0);
        if (v.st) begin
            instr = '0;
            chk({nm, ".st_done"}, {30'h0, stall_o, rd_we_o}, 0);
            return;
        end
        chk({nm, ".rsp_stall"}, 32'(stall_o), 1);
        k = 0;
        while (stall_o && k < 20) begin
            dmem.rsp_valid = (k == v.rsp);
            dmem.rdata = (k == v.rsp) ? v.rdata : 32'h5A5A_5A5A;
            @(posedge clk); #1;
            k++;
        end
        dmem.rsp_valid = 1'b0; instr = '0;
        ek = v.err ? T : v.rsp + 1;
        chk({nm, ".latency"}, k, ek);
        chk({nm, ".rd_we"}, 32'(rd_we_o), 32'(v.we));
        chk({nm, ".bus_err"}, 32'(bus_err_o), 32'(v.err));
        if (v.we) begin
            chk({nm, ".rd_sel"}, 32'(rd_sel_o), 32'(v.sel));
            chk({nm, ".rd_data"}, rd_data_o, v.data);
        end
        @(posedge clk); #1;
        chk({nm, ".pulse"}, {30'h0, rd_we_o, bus_err_o}, 0);
    endtask

    vec_t tbl[$];

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem.req_ready = 1'b0; dmem.rsp_valid = 1'b0; dmem.rdata = '0;

        tbl.push_back(mk(r_add(5), 32'hAA, 0, 0, 0, 0,
                         0, 0, 0, 1, 0, 5, 0, 0, 0, 32'hAA));
        tbl.push_back(mk(i_load(F3_LB, 3), 32'h1003, 0, 32'h80FF_FFFF, 2, 0,
                         1, 0, 0, 1, 0, 3, 32'h1000, 0, 0, 32'hFFFF_FF80));
        tbl.push_back(mk(i_load(F3_LHU, 4), 32'h2002, 0, 32'hBEEF_1234, 0, 1,
                         1, 0, 0, 1, 0, 4, 32'h2000, 0, 0, 32'h0000_BEEF));
        tbl.push_back(mk(s_store(F3_SH), 32'h2002, 32'h0000_ABCD, 0, 1, 0,
                         1, 1, 0, 0, 0, 0, 32'h2000, 4'b1100, 32'hABCD_0000, 0));
        tbl.push_back(mk(i_load(F3_LW, 1), 32'h3001, 0, 0, 0, 0,
                         0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(i_load(F3_LW, 6), 32'h4000, 0, 32'h1111_2222, 0, 6,
                         1, 0, 0, 0, 1, 6, 32'h4000, 0, 0, 0));
        tbl.push_back(mk(i_load(F3_LW, 7), 32'h4004, 0, 32'h1234_5678, 0, 3,
                         1, 0, 0, 1, 0, 7, 32'h4004, 0, 0, 32'h1234_5678));
        tbl.push_back(mk(i_load(F3_LW, 0), 32'h4008, 0, 32'hCAFE_F00D, 1, 0,
                         1, 0, 0, 0, 0, 0, 32'h4008, 0, 0, 0));
        tbl.push_back(mk(r_add(0), 32'h77, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(s_store(F3_SB), 32'h5001, 32'h1234_56A5, 0, 0, 0,
                         1, 1, 0, 0, 0, 0, 32'h5000, 4'b0010, 32'h3456_A500, 0));
        tbl.push_back(mk(i_load(F3_LH, 8), 32'h5002, 0, 32'h8001_0000, 0, 2,
                         1, 0, 0, 1, 0, 8, 32'h5000, 0, 0, 32'hFFFF_8001));
        tbl.push_back(mk(i_load(F3_LBU, 9), 32'h5000, 0, 32'h0000_00F0, 0, 0,
                         1, 0, 0, 1, 0, 9, 32'h5000, 0, 0, 32'h0000_00F0));
        tbl.push_back(mk(i_load(F3_LH, 2), 32'h5001, 0, 0, 0, 0,
                         0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(s_store(F3_SW), 32'h5002, 0, 0, 0, 0,
                         0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(s_store(F3_SH), 32'h5003, 0, 0, 0, 0,
                         0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h0050_0293, 32'h5, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(s_store(F3_SW), 32'h600C, 32'hDEAD_BEEF, 0, 3, 0,
                         1, 1, 0, 0, 0, 0, 32'h600C, 4'hF, 32'hDEAD_BEEF, 0));
        tbl[1].noise = 1'b1;

        #2;
        chk("reset.outs", {26'h0, stall_o, dmem.req_valid, dmem.we,
                           rd_we_o, misalign_o, bus_err_o}, 0);
        chk("reset.addr", dmem.addr, 0);
        chk("reset.wstrb", 32'(dmem.wstrb), 0);
        chk("reset.wdata", dmem.wdata, 0);
        chk("reset.rd_sel", 32'(rd_sel_o), 0);
        chk("reset.rd_data", rd_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Reset while a request is waiting for ready.
        @(negedge clk);
        instr = i_load(F3_LW, 5); alu_result = 32'h7000;
        @(posedge clk); #1;
        chk("rst_mid.req", 32'(dmem.req_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.async", {30'h0, dmem.req_valid, stall_o}, 0);
        chk("rst_mid.addr", dmem.addr, 0);
        chk("rst_mid.rd_data", rd_data_o, 0);
        dmem.req_ready = 1'b1; instr = '0;
        @(negedge clk);
        rst_n = 1'b1; dmem.req_ready = 1'b0;
        dmem.rsp_valid = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("rst_mid.after", {29'h0, rd_we_o, dmem.req_valid, stall_o}, 0);
        dmem.rsp_valid = 1'b0;

        for (int i = 0; i < 80; i++) run(gen(), $sformatf("rnd%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
